// File: rtl/cache_mem_arbiter.sv
// Shares one physical-memory line port between the icache and dcache miss/write-back paths.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; the default is fixed dcache priority.
module cache_mem_arbiter #(
  parameter int unsigned LINE_W = 256,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, RELEASE} state_t;

  state_t            state, state_n;
  logic              read_n, write_n;
  logic [ADDR_W-1:0] address_n;
  logic [LINE_W-1:0] wdata_n;
  logic              i_req, d_req, grant_d;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

`ifdef ARB_ROUND_ROBIN_EN
  // last_grant_d = 1 when the dcache won the most recent grant
  logic last_grant_d, last_grant_d_n;

  always_ff @(posedge clk) begin
    if (rst) last_grant_d <= 1'b0;
    else     last_grant_d <= last_grant_d_n;
  end

  assign grant_d = d_req & (~i_req | ~last_grant_d);
`else
  // MEM stage is older than IF, so the dcache wins any conflict
  assign grant_d = d_req;
`endif

  // Data always mirrors memory; resp is the only qualifier and only for the served side
  assign i_pmem_rdata = mem_rdata;
  assign d_pmem_rdata = mem_rdata;
  assign i_pmem_resp  = (state == SERVE_I) & mem_resp;
  assign d_pmem_resp  = (state == SERVE_D) & mem_resp;

  // State and latched command registers (these directly drive the memory port)
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_address <= '0;
      mem_wdata   <= '0;
    end else begin
      state       <= state_n;
      mem_read    <= read_n;
      mem_write   <= write_n;
      mem_address <= address_n;
      mem_wdata   <= wdata_n;
    end
  end

  always_comb begin
    state_n   = state;
    read_n    = mem_read;
    write_n   = mem_write;
    address_n = mem_address;
    wdata_n   = mem_wdata;
`ifdef ARB_ROUND_ROBIN_EN
    last_grant_d_n = last_grant_d;
`endif
    case (state)
      IDLE: begin
        if (grant_d) begin
          // A write-back wins over a simultaneous (illegal) read
          state_n   = SERVE_D;
          write_n   = d_pmem_write;
          read_n    = ~d_pmem_write;
          address_n = d_pmem_address;
          wdata_n   = d_pmem_wdata;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d_n = 1'b1;
`endif
        end else if (i_req) begin
          state_n   = SERVE_I;
          read_n    = 1'b1;
          write_n   = 1'b0;
          address_n = i_pmem_address;
          wdata_n   = '0;
`ifdef ARB_ROUND_ROBIN_EN
          last_grant_d_n = 1'b0;
`endif
        end
      end
      SERVE_I, SERVE_D: begin
        if (mem_resp) begin
          state_n = RELEASE;
          read_n  = 1'b0;
          write_n = 1'b0;
        end
      end
      RELEASE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

endmodule
